// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: clips one rectangle command to the visible screen and
// emits one pixel write per clock in raster order toward video memory.
module rect_fill_engine #(
  parameter int unsigned H_PIXELS     = 320,
  parameter int unsigned V_PIXELS     = 240,
  parameter int unsigned X_WIDTH      = 9,
  parameter int unsigned Y_WIDTH      = 8,
  parameter int unsigned COLOUR_WIDTH = 3
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [X_WIDTH-1:0]      rect_x,
  input  logic [Y_WIDTH-1:0]      rect_y,
  input  logic [X_WIDTH-1:0]      rect_w,
  input  logic [Y_WIDTH-1:0]      rect_h,
  input  logic [COLOUR_WIDTH-1:0] colour,
  output logic                    ready,
  output logic                    plot,
  output logic [X_WIDTH-1:0]      x,
  output logic [Y_WIDTH-1:0]      y,
  output logic [COLOUR_WIDTH-1:0] colour_out,
  output logic                    done
);

  localparam logic [X_WIDTH:0] HLim = H_PIXELS[X_WIDTH:0];
  localparam logic [Y_WIDTH:0] VLim = V_PIXELS[Y_WIDTH:0];
  localparam logic [X_WIDTH:0] XOne = 1;
  localparam logic [Y_WIDTH:0] YOne = 1;

  typedef enum logic [1:0] {StIdle, StDraw, StDone} state_e;

  state_e             state_q;
  logic [X_WIDTH-1:0] x_start_q;
  logic [X_WIDTH:0]   x_end_q;
  logic [Y_WIDTH:0]   y_end_q;

  logic [X_WIDTH:0]   x_sum, x_end_d;
  logic [Y_WIDTH:0]   y_sum, y_end_d;
  logic               empty_cmd, x_last, y_last;

  // Ends are exclusive and one bit wider so rect_x+rect_w cannot wrap.
  always_comb begin
    x_sum     = {1'b0, rect_x} + {1'b0, rect_w};
    y_sum     = {1'b0, rect_y} + {1'b0, rect_h};
    x_end_d   = (x_sum > HLim) ? HLim : x_sum;
    y_end_d   = (y_sum > VLim) ? VLim : y_sum;
    empty_cmd = (rect_w == '0) || (rect_h == '0) ||
                ({1'b0, rect_x} >= HLim) || ({1'b0, rect_y} >= VLim);
    x_last    = (({1'b0, x} + XOne) == x_end_q);
    y_last    = (({1'b0, y} + YOne) == y_end_q);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      ready      <= 1'b1;
      plot       <= 1'b0;
      done       <= 1'b0;
      x          <= '0;
      y          <= '0;
      colour_out <= '0;
      x_start_q  <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            ready      <= 1'b0;
            colour_out <= colour;
            x_start_q  <= rect_x;
            x_end_q    <= x_end_d;
            y_end_q    <= y_end_d;
            if (empty_cmd) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else begin
              state_q <= StDraw;
              plot    <= 1'b1;
              x       <= rect_x;
              y       <= rect_y;
            end
          end
        end
        StDraw: begin
          if (x_last) begin
            if (y_last) begin
              state_q <= StDone;
              plot    <= 1'b0;
              done    <= 1'b1;
            end else begin
              x <= x_start_q;
              y <= y + 1'b1;
            end
          end else begin
            x <= x + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done    <= 1'b0;
          ready   <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          plot    <= 1'b0;
          done    <= 1'b0;
          ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule
